// File: rtl/train_balancer_sequencer.sv
// train_balancer_sequencer
//
// Balances NUM_STATIONS dropoff stations in one run. On an accepted start
// it snapshots every station's inputs. It then walks the stations one per
// cycle twice. The first walk finds each station's stored percentage. A
// single cycle then averages them. The second walk derives each station's
// train limit. All results are published together on a one-cycle done pulse.
//
// Ports
//   clk                     rising-edge clock
//   reset                   synchronous, active-high; aborts any run
//   start                   request a run (honoured only while idle)
//   precision               percentage scale P
//   station_enable          bit i includes station i
//   units_flat              U per station, station i at [i*(INT+1) +: INT+1]
//   train_count_flat        C per station
//   stopped_train_id_flat   T per station (0 = no stopped train)
//   busy                    high whenever the sequencer is not idle
//   done                    one-cycle pulse while results are being published
//   percentage_stored_flat  published S per station
//   trains_limit_flat       published L per station
//   total_percentage_stored published network total R
module train_balancer_sequencer #(
  parameter int NUM_STATIONS        = 4,
  parameter int QUEUE_LENGTH        = 3,
  parameter int MAX_STOREABLE       = 128000,
  parameter int UNITS_IN_TRAIN_LOAD = 8000,
  parameter int INT                 = 31
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INT:0]                     precision,
  input  logic [NUM_STATIONS-1:0]          station_enable,
  input  logic [NUM_STATIONS*(INT+1)-1:0]  units_flat,
  input  logic [NUM_STATIONS*(INT+1)-1:0]  train_count_flat,
  input  logic [NUM_STATIONS*(INT+1)-1:0]  stopped_train_id_flat,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_STATIONS*(INT+1)-1:0]  percentage_stored_flat,
  output logic [NUM_STATIONS*(INT+1)-1:0]  trains_limit_flat,
  output logic [INT:0]                     total_percentage_stored
);

  localparam int DW = INT + 1;
  localparam int WW = 2 * DW;
  localparam int IW = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STATIONS - 1);
  localparam logic [WW-1:0] M_W      = WW'(MAX_STOREABLE);
  localparam logic [WW-1:0] W_W      = WW'(UNITS_IN_TRAIN_LOAD);
  localparam logic [WW-1:0] Q_W      = WW'(QUEUE_LENGTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PASS1 = 3'd1;
  localparam logic [2:0] S_AVG   = 3'd2;
  localparam logic [2:0] S_PASS2 = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              r_state;
  logic [IW-1:0]           r_idx;
  logic [DW-1:0]           r_p;
  logic [NUM_STATIONS-1:0] r_en;
  logic [DW-1:0]           r_u  [NUM_STATIONS];
  logic [DW-1:0]           r_c  [NUM_STATIONS];
  logic [DW-1:0]           r_t  [NUM_STATIONS];
  logic [DW-1:0]           r_s  [NUM_STATIONS];
  logic [WW-1:0]           r_sa [NUM_STATIONS];
  logic [DW-1:0]           r_l  [NUM_STATIONS];
  logic [WW-1:0]           r_total;
  logic [DW-1:0]           r_cnt;
  logic [WW-1:0]           r_avg;
  logic [NUM_STATIONS*DW-1:0] r_out_s;
  logic [NUM_STATIONS*DW-1:0] r_out_l;
  logic [DW-1:0]           r_out_r;

  // Per-station arithmetic for the station selected by r_idx; shared by both passes.
  logic [DW-1:0] w_z;
  logic [WW-1:0] w_u, w_p, w_p_safe, w_a, w_s, w_sa;
  logic [WW-1:0] w_free, w_tf, w_diff, w_td_raw, w_td, w_lim;
  logic          w_l_zero;
  logic [DW-1:0] w_l;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_z      = '0;
    w_u      = {{DW{1'b0}}, r_u[r_idx]};
    w_p      = {{DW{1'b0}}, r_p};
    // Divisor kept non-zero; every P==0 result is forced to 0 separately.
    w_p_safe = (r_p == '0) ? WW'(1) : w_p;

    // A stopped train is already partly unloaded, so it counts one load less.
    if (r_t[r_idx] == '0)      w_z = r_c[r_idx];
    else if (r_c[r_idx] != '0) w_z = r_c[r_idx] - DW'(1);

    w_a  = w_u + {{DW{1'b0}}, w_z} * W_W;
    w_s  = (w_a * w_p) / M_W;
    w_sa = (w_u * w_p) / M_W;

    w_free   = (w_a > M_W) ? '0 : (M_W - w_a);
    w_tf     = w_free / W_W;
    w_diff   = r_avg - r_sa[r_idx];
    w_td_raw = ((w_diff * M_W) / w_p_safe) / W_W;
    // A station below average always gets at least one train.
    w_td     = (w_td_raw == '0) ? WW'(1) : w_td_raw;

    w_lim = w_tf;
    if (w_td < w_lim) w_lim = w_td;
    if (Q_W < w_lim)  w_lim = Q_W;

    w_l_zero = !r_en[r_idx] || (r_cnt == '0) || (r_p == '0) || (r_sa[r_idx] > r_avg);
    w_l      = w_l_zero ? '0 : w_lim[DW-1:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_p     <= '0;
      r_en    <= '0;
      r_total <= '0;
      r_cnt   <= '0;
      r_avg   <= '0;
      r_out_s <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      // NOTE: the per-station working arrays are cleared too, so a reset leaves no stale station data behind.
      for (int i = 0; i < NUM_STATIONS; i++) begin
        r_u[i]  <= '0;
        r_c[i]  <= '0;
        r_t[i]  <= '0;
        r_s[i]  <= '0;
        r_sa[i] <= '0;
        r_l[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p     <= precision;
            r_en    <= station_enable;
            r_idx   <= '0;
            r_total <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_STATIONS; i++) begin
              r_u[i] <= units_flat[i*DW +: DW];
              r_c[i] <= train_count_flat[i*DW +: DW];
              r_t[i] <= stopped_train_id_flat[i*DW +: DW];
            end
            r_state <= S_PASS1;
          end
        end
        S_PASS1: begin
          if (r_en[r_idx]) begin
            r_total      <= r_total + w_s;
            r_cnt        <= r_cnt + DW'(1);
            r_s[r_idx]   <= w_s[DW-1:0];
            r_sa[r_idx]  <= w_sa;
          end else begin
            r_s[r_idx]   <= '0;
            r_sa[r_idx]  <= '0;
          end
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_AVG;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_AVG: begin
          r_avg   <= (r_cnt == '0) ? '0 : r_total / {{DW{1'b0}}, r_cnt};
          r_state <= S_PASS2;
        end
        S_PASS2: begin
          r_l[r_idx] <= w_l;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          for (int i = 0; i < NUM_STATIONS; i++) begin
            r_out_s[i*DW +: DW] <= r_s[i];
            r_out_l[i*DW +: DW] <= r_l[i];
          end
          r_out_r <= r_total[DW-1:0];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy                    = (r_state != S_IDLE);
  assign done                    = (r_state == S_DONE);
  assign percentage_stored_flat  = r_out_s;
  assign trains_limit_flat       = r_out_l;
  assign total_percentage_stored = r_out_r;

endmodule

// File: tb/tb_train_balancer_sequencer.sv
// Directed testbench for train_balancer_sequencer (4 stations, M=128000,
// W=8000, Q=3). Inputs are driven and outputs sampled on the falling edge.
module tb_train_balancer_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  precision;
  logic [3:0]   station_enable;
  logic [127:0] units_flat;
  logic [127:0] train_count_flat;
  logic [127:0] stopped_train_id_flat;
  logic         busy;
  logic         done;
  logic [127:0] percentage_stored_flat;
  logic [127:0] trains_limit_flat;
  logic [31:0]  total_percentage_stored;

  int n_checks = 0;
  int n_fail   = 0;

  train_balancer_sequencer #(
    .NUM_STATIONS(4), .QUEUE_LENGTH(3), .MAX_STOREABLE(128000),
    .UNITS_IN_TRAIN_LOAD(8000), .INT(31)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .precision(precision),
    .station_enable(station_enable), .units_flat(units_flat),
    .train_count_flat(train_count_flat), .stopped_train_id_flat(stopped_train_id_flat),
    .busy(busy), .done(done), .percentage_stored_flat(percentage_stored_flat),
    .trains_limit_flat(trains_limit_flat), .total_percentage_stored(total_percentage_stored)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic set_defaults();
    precision             = 32'd1000;
    station_enable        = 4'b1111;
    train_count_flat      = '0;
    stopped_train_id_flat = '0;
    units_flat            = pack4(64000, 64000, 64000, 64000);
  endtask

  // Pulse start from a falling edge and wait (bounded) for done.
  // cyc is the cycle number of done, counting the accept cycle as 0.
  // Returns on the falling edge of the cycle after done.
  task automatic do_run(output int cyc, output logic busy_at_done,
                        output logic done_after, output logic busy_after);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    busy_at_done = busy;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    set_defaults();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (percentage_stored_flat !== '0 || trains_limit_flat !== '0 || total_percentage_stored !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: S=%h L=%h R=%0d required all 0",
               percentage_stored_flat, trains_limit_flat, total_percentage_stored);
    end
  endtask

  task automatic test_uniform();
    int cyc; logic bd, da, ba;
    set_defaults();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL uniform_busy_rise: busy=%b required 1", busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    bd = busy;
    @(negedge clk);
    da = done;
    ba = busy;
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL uniform_done_cycle: got %0d required 10", cyc);
    end
    n_checks++;
    if (bd !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin
      n_fail++;
      $display("FAIL uniform_handshake: busy@done=%b done_after=%b busy_after=%b required 1 0 0", bd, da, ba);
    end
    n_checks++;
    if (percentage_stored_flat !== pack4(500, 500, 500, 500)) begin
      n_fail++;
      $display("FAIL uniform_S: got %h required %h", percentage_stored_flat, pack4(500, 500, 500, 500));
    end
    n_checks++;
    if (total_percentage_stored !== 32'd2000) begin
      n_fail++;
      $display("FAIL uniform_R: got %0d required 2000", total_percentage_stored);
    end
    n_checks++;
    if (trains_limit_flat !== pack4(1, 1, 1, 1)) begin
      n_fail++;
      $display("FAIL uniform_L: got %h required %h", trains_limit_flat, pack4(1, 1, 1, 1));
    end
  endtask

  task automatic test_mixed();
    int cyc; logic bd, da, ba;
    set_defaults();
    units_flat = pack4(0, 128000, 64000, 32000);
    do_run(cyc, bd, da, ba);
    n_checks++;
    if (percentage_stored_flat !== pack4(0, 1000, 500, 250)) begin
      n_fail++;
      $display("FAIL mixed_S: got %h required %h", percentage_stored_flat, pack4(0, 1000, 500, 250));
    end
    n_checks++;
    if (total_percentage_stored !== 32'd1750) begin
      n_fail++;
      $display("FAIL mixed_R: got %0d required 1750", total_percentage_stored);
    end
    n_checks++;
    if (trains_limit_flat !== pack4(3, 0, 0, 2)) begin
      n_fail++;
      $display("FAIL mixed_L: got %h required %h", trains_limit_flat, pack4(3, 0, 0, 2));
    end
  endtask

  task automatic test_train_count();
    int cyc; logic bd, da, ba;
    int c_tab [3] = '{2, 2, 0};
    int t_tab [3] = '{0, 5, 5};
    int s_tab [3] = '{125, 62, 0};
    int r_tab [3] = '{1625, 1562, 1500};
    for (int k = 0; k < 3; k++) begin
      set_defaults();
      units_flat            = pack4(0, 64000, 64000, 64000);
      train_count_flat      = pack4(c_tab[k], 0, 0, 0);
      stopped_train_id_flat = pack4(t_tab[k], 0, 0, 0);
      do_run(cyc, bd, da, ba);
      n_checks++;
      if (percentage_stored_flat[31:0] !== 32'(s_tab[k])) begin
        n_fail++;
        $display("FAIL train_count_S0[%0d]: got %0d required %0d", k, percentage_stored_flat[31:0], s_tab[k]);
      end
      n_checks++;
      if (total_percentage_stored !== 32'(r_tab[k])) begin
        n_fail++;
        $display("FAIL train_count_R[%0d]: got %0d required %0d", k, total_percentage_stored, r_tab[k]);
      end
    end
    n_checks++;
    if (trains_limit_flat !== pack4(3, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL train_count_L: got %h required %h", trains_limit_flat, pack4(3, 0, 0, 0));
    end
    set_defaults();
  endtask

  task automatic test_enable();
    int cyc; logic bd, da, ba;
    set_defaults();
    units_flat     = pack4(0, 128000, 64000, 32000);
    station_enable = 4'b0011;
    do_run(cyc, bd, da, ba);
    n_checks++;
    if (percentage_stored_flat !== pack4(0, 1000, 0, 0) || total_percentage_stored !== 32'd1000) begin
      n_fail++;
      $display("FAIL enable_partial_SR: S=%h R=%0d required S=%h R=1000",
               percentage_stored_flat, total_percentage_stored, pack4(0, 1000, 0, 0));
    end
    n_checks++;
    if (trains_limit_flat !== pack4(3, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL enable_partial_L: got %h required %h", trains_limit_flat, pack4(3, 0, 0, 0));
    end
    station_enable = 4'b0000;
    do_run(cyc, bd, da, ba);
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL enable_none_done_cycle: got %0d required 10", cyc);
    end
    n_checks++;
    if (percentage_stored_flat !== '0 || trains_limit_flat !== '0 || total_percentage_stored !== '0) begin
      n_fail++;
      $display("FAIL enable_none_outputs: S=%h L=%h R=%0d required all 0",
               percentage_stored_flat, trains_limit_flat, total_percentage_stored);
    end
  endtask

  // Run 1 then run 2 back-to-back; outputs hold run-1 values until run 2
  // publishes, and a start (plus input changes) mid-run is ignored.
  task automatic test_back_to_back();
    int cyc; int extra_done; logic bd, da, ba;
    set_defaults();
    do_run(cyc, bd, da, ba);
    units_flat = pack4(0, 128000, 64000, 32000);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 3) begin
        start      = 1'b1;
        units_flat = pack4(7, 7, 7, 7);
        precision  = 32'd3;
      end
      if (cyc == 4) start = 1'b0;
      if (cyc == 5) begin
        n_checks++;
        if (total_percentage_stored !== 32'd2000 || percentage_stored_flat !== pack4(500, 500, 500, 500)) begin
          n_fail++;
          $display("FAIL b2b_hold_midrun: S=%h R=%0d required run-1 values R=2000",
                   percentage_stored_flat, total_percentage_stored);
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: got %0d required 10", cyc);
    end
    n_checks++;
    if (total_percentage_stored !== 32'd2000 || trains_limit_flat !== pack4(1, 1, 1, 1)) begin
      n_fail++;
      $display("FAIL b2b_hold_at_done: R=%0d L=%h required 2000 %h",
               total_percentage_stored, trains_limit_flat, pack4(1, 1, 1, 1));
    end
    @(negedge clk);
    n_checks++;
    if (percentage_stored_flat !== pack4(0, 1000, 500, 250) || total_percentage_stored !== 32'd1750 ||
        trains_limit_flat !== pack4(3, 0, 0, 2)) begin
      n_fail++;
      $display("FAIL b2b_run2_results: S=%h R=%0d L=%h required %h 1750 %h",
               percentage_stored_flat, total_percentage_stored, trains_limit_flat,
               pack4(0, 1000, 500, 250), pack4(3, 0, 0, 2));
    end
    extra_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done++;
      @(negedge clk);
    end
    n_checks++;
    if (extra_done != 0) begin
      n_fail++;
      $display("FAIL b2b_ignored_start: got %0d busy/done cycles required 0", extra_done);
    end
    set_defaults();
  endtask

  task automatic test_abort();
    int cyc; int late_done;
    set_defaults();
    units_flat = pack4(0, 128000, 64000, 32000);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (percentage_stored_flat !== '0 || trains_limit_flat !== '0 || total_percentage_stored !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: S=%h L=%h R=%0d required all 0",
               percentage_stored_flat, trains_limit_flat, total_percentage_stored);
    end
    late_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) late_done++;
    end
    n_checks++;
    if (late_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done cycles required 0", late_done);
    end
  endtask

  task automatic test_reset_start();
    set_defaults();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_busy: got %b required 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_after: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_zero_precision();
    int cyc; logic bd, da, ba;
    set_defaults();
    do_run(cyc, bd, da, ba);
    units_flat = pack4(0, 128000, 64000, 32000);
    precision  = 32'd0;
    do_run(cyc, bd, da, ba);
    n_checks++;
    if (cyc != 10) begin
      n_fail++;
      $display("FAIL zero_p_done_cycle: got %0d required 10", cyc);
    end
    n_checks++;
    if (percentage_stored_flat !== '0 || trains_limit_flat !== '0 || total_percentage_stored !== '0) begin
      n_fail++;
      $display("FAIL zero_p_outputs: S=%h L=%h R=%0h required all 0",
               percentage_stored_flat, trains_limit_flat, total_percentage_stored);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_defaults();
    @(negedge clk);
    test_reset();
    test_uniform();
    test_mixed();
    test_train_count();
    test_enable();
    test_back_to_back();
    test_abort();
    test_reset_start();
    test_zero_precision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/train_balancer_sequencer.md
# train_balancer_sequencer

Multi-station successor to the single-station dropoff calculator. It balances `NUM_STATIONS` dropoff stations in one pass set. The block captures per-station inputs on `start`, then computes in sequence, one station per cycle: units accounted, percentage stored, network total, average and train limit. It publishes all results atomically with a one-cycle `done` pulse. It sits between the station signal aggregator and the per-station train-limit drivers.

## Interface
- `NUM_STATIONS`, 4, number of stations (G); ≥1.
- `QUEUE_LENGTH`, 3, max trains limit per station (Q).
- `MAX_STOREABLE`, 128000, per-station capacity in units (M).
- `UNITS_IN_TRAIN_LOAD`, 8000, units per train (W).
- `INT`, 31, MSB index of every scalar; scalars are INT+1 bits.

- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a balancing run; accepted only in IDLE.
- `precision` in INT+1: percentage scale (P).
- `station_enable` in NUM_STATIONS: bit i includes station i.
- `units_flat` in NUM_STATIONS*(INT+1): U per station; station i at [i*(INT+1) +: INT+1].
- `train_count_flat` in NUM_STATIONS*(INT+1): C per station.
- `stopped_train_id_flat` in NUM_STATIONS*(INT+1): T per station.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when results publish.
- `percentage_stored_flat` out NUM_STATIONS*(INT+1): published S per station.
- `trains_limit_flat` out NUM_STATIONS*(INT+1): published L per station.
- `total_percentage_stored` out INT+1: published R.

## Operation
- FSM states: IDLE → PASS1 → AVG → PASS2 → DONE → IDLE.
- IDLE, `start`=1: capture P, `station_enable`, and all U/C/T into working registers. Clear idx, total and enabled-count. Go to PASS1.
- PASS1, one station per cycle, idx 0..N-1:
  - A = U + Z·W, where Z = C if T==0, else C-1 saturated at 0.
  - S = A·P/M.
  - Sa = U·P/M.
  - If enabled: total += S, count += 1, store S and Sa. If disabled: store S=0 and Sa=0.
  - At idx N-1, go to AVG.
- AVG, one cycle: avg = total/count, with avg = 0 when count==0. Go to PASS2.
- PASS2, one station per cycle:
  - L = 0 if the station is disabled, count==0, P==0, or Sa > avg.
  - Otherwise:
    - free = M - A, saturated at 0.
    - tf = free/W.
    - td = ((avg-Sa)·M/P)/W, forced to 1 when 0.
    - L = min(tf, td, Q).
  - At idx N-1, go to DONE.
- DONE, one cycle: copy working S, L and total to the output registers, assert `done`, go to IDLE.
- All products and quotients use 2·(INT+1)-bit intermediates. Results are truncated to INT+1 bits only at the stored value.
- P==0: all S, R and L are 0, with no division by zero.
- `start` while busy is ignored. No queuing.
- Input changes after capture have no effect on the run in progress.

## Timing
- Reset: state IDLE. `busy`=0, `done`=0, all published outputs 0, working registers 0.
- The accept edge is the edge where IDLE and `start`=1.
- `busy` rises in the cycle after accept.
- `done` is high in cycle 2·NUM_STATIONS+2 after the accept cycle, for exactly 1 cycle. `busy` is also high in that cycle.
- `busy` falls the cycle after `done`.
- Back-to-back runs: the earliest next accept is the cycle after `done`.
- Published outputs change only on the DONE edge. They hold their values between runs and through a run in progress.
- `reset` mid-run aborts immediately. The next cycle shows IDLE and all outputs 0. The run's results are discarded.
- `reset` and `start` high together: reset wins, and the start is not accepted.

## Test plan
Common configuration: N=4, M=128000, W=8000, Q=3, P=1000, all stations enabled, C=0 and T=0 unless stated.

1. All U=64000 → S={500,500,500,500}, R=2000, L={1,1,1,1}. `done` occurs exactly 10 cycles after accept.
2. U={0,128000,64000,32000} → S={0,1000,500,250}, R=1750 (avg 437), L={3,0,0,2}.
3. Station 0 with U=0:
   - C=2, T=0 → S0=125.
   - C=2, T=5 → S0=62.
   - C=0, T=5 → S0=0 (saturation, no wrap).
4. U as in test 2 with `station_enable`=4'b0011 → S={0,1000,0,0}, R=1000 (avg 500), L={3,0,0,0}. With `station_enable`=0 → all outputs 0, and `done` still arrives at cycle 10.
5. Hold-and-abort sequence:
   - Complete test 1, then start test 2.
   - Outputs keep test 1 values until test 2's `done`.
   - A second `start` during the run is ignored.
   - `reset` at the second PASS2 cycle → the next cycle shows `busy`=0, `done`=0, all outputs 0, and no `done` follows.
6. P=0 with test 2 inputs → all S, L and R are 0. `done` arrives on time with no X values.
